// File: rtl/parking_meter_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_meter_counter_pkg
// Description : Shared constants for the parking meter countdown datapath:
//               BCD geometry, default credit/preset values as packed BCD,
//               and decimal <-> packed-BCD conversion helpers for
//               elaboration-time parameter handling.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_meter_counter_pkg;

  localparam int c_DIGIT_W    = 4;
  localparam int c_NUM_DIGITS = 4;
  localparam int c_BCD_W      = c_DIGIT_W * c_NUM_DIGITS;

  // Default credit and preset values, packed BCD
  localparam logic [15:0] c_ADD0_BCD    = 16'h0010;
  localparam logic [15:0] c_ADD1_BCD    = 16'h0180;
  localparam logic [15:0] c_ADD2_BCD    = 16'h0200;
  localparam logic [15:0] c_ADD3_BCD    = 16'h0550;
  localparam logic [15:0] c_PRESET0_BCD = 16'h0015;
  localparam logic [15:0] c_PRESET1_BCD = 16'h0150;

  // Packed BCD to decimal, used so decimal parameter defaults track the BCD constants
  function automatic int f_bcd_to_dec(input logic [15:0] bcd);
    int v;
    v = 0;
    for (int i = c_NUM_DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + int'(bcd[i*c_DIGIT_W +: c_DIGIT_W]);
    end
    return v;
  endfunction

  // Decimal to packed BCD, evaluated only on parameters
  function automatic logic [15:0] f_dec_to_bcd(input int dec);
    logic [15:0] r;
    int          v;
    r = '0;
    v = dec;
    for (int i = 0; i < c_NUM_DIGITS; i++) begin
      r[i*c_DIGIT_W +: c_DIGIT_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_meter_counter_bcd4_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : bcd4_add_sub
// Description : Combinational 4-digit packed-BCD adder/subtractor with
//               per-digit +6 (add) / -6 (subtract) correction. cout is the
//               digit-3 carry on add and the digit-3 borrow on subtract.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd4_add_sub
  import parking_meter_counter_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] result,
  output logic        cout
);

  // Ripple through the digits; the chain lives in one block so it is a single combinational path
  always_comb begin
    logic       w_c;
    logic [4:0] w_raw;
    logic [3:0] w_dig;
    w_c    = 1'b0;
    result = '0;
    for (int i = 0; i < c_NUM_DIGITS; i++) begin
      if (sub) begin
        w_raw = {1'b0, a[i*c_DIGIT_W +: c_DIGIT_W]} - {1'b0, b[i*c_DIGIT_W +: c_DIGIT_W]} - {4'd0, w_c};
        // A negative digit wrapped mod 16; subtracting 6 brings it back into mod 10
        w_c   = w_raw[4];
        w_dig = w_c ? (w_raw[3:0] - 4'd6) : w_raw[3:0];
      end else begin
        w_raw = {1'b0, a[i*c_DIGIT_W +: c_DIGIT_W]} + {1'b0, b[i*c_DIGIT_W +: c_DIGIT_W]} + {4'd0, w_c};
        // A digit sum above 9 skips the six unused codes
        w_c   = (w_raw > 5'd9);
        w_dig = w_c ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
      end
      result[i*c_DIGIT_W +: c_DIGIT_W] = w_dig;
    end
    cout = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/parking_meter_counter.sv
`default_nettype none
// ============================================================================
// Module      : parking_meter_counter
// Description : Four-digit BCD countdown meter. Presets and add buttons load
//               or credit time (saturating), a 2 Hz tick decrements once per
//               second, and the display enable blinks at low time and
//               flashes at 2 Hz when expired.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_meter_counter
  import parking_meter_counter_pkg::*;
#(
  parameter int MAX_COUNT  = 9999,
  parameter int LOW_THRESH = 200,
  parameter int ADD0       = f_bcd_to_dec(c_ADD0_BCD),
  parameter int ADD1       = f_bcd_to_dec(c_ADD1_BCD),
  parameter int ADD2       = f_bcd_to_dec(c_ADD2_BCD),
  parameter int ADD3       = f_bcd_to_dec(c_ADD3_BCD),
  parameter int PRESET0    = f_bcd_to_dec(c_PRESET0_BCD),
  parameter int PRESET1    = f_bcd_to_dec(c_PRESET1_BCD)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_2hz,
  input  logic [3:0]  add_req,
  input  logic [1:0]  preset_req,
  output logic [15:0] BCD_16bit,
  output logic        En_7seg
);

  localparam logic [15:0] c_MAX_BCD     = f_dec_to_bcd(MAX_COUNT);
  localparam logic [15:0] c_LOW_BCD     = f_dec_to_bcd(LOW_THRESH);
  localparam logic [15:0] c_ADD0_V      = f_dec_to_bcd(ADD0);
  localparam logic [15:0] c_ADD1_V      = f_dec_to_bcd(ADD1);
  localparam logic [15:0] c_ADD2_V      = f_dec_to_bcd(ADD2);
  localparam logic [15:0] c_ADD3_V      = f_dec_to_bcd(ADD3);
  localparam logic [15:0] c_PRESET0_V   = f_dec_to_bcd(PRESET0);
  localparam logic [15:0] c_PRESET1_V   = f_dec_to_bcd(PRESET1);
  localparam logic [15:0] c_ONE_BCD     = 16'h0001;

  logic [15:0] r_count;
  logic        r_phase;
  logic        r_en;

  logic        w_is_add;
  logic        w_boundary;
  logic [15:0] w_operand;
  logic [15:0] w_alu_res;
  logic        w_alu_cout;
  logic        w_sat;
  logic [15:0] w_count_nxt;
  logic        w_en_nxt;

  assign w_is_add   = |add_req;
  assign w_boundary = tick_2hz & r_phase;

  // Second ALU operand: lowest-numbered add button wins, otherwise a unit decrement
  always_comb begin
    w_operand = c_ONE_BCD;
    if      (add_req[0]) w_operand = c_ADD0_V;
    else if (add_req[1]) w_operand = c_ADD1_V;
    else if (add_req[2]) w_operand = c_ADD2_V;
    else if (add_req[3]) w_operand = c_ADD3_V;
  end

  bcd4_add_sub u_alu (
    .a      (r_count),
    .b      (w_operand),
    .sub    (~w_is_add),
    .result (w_alu_res),
    .cout   (w_alu_cout)
  );

  // Legal BCD orders the same as binary, so a plain magnitude compare works
  assign w_sat = w_alu_cout | (w_alu_res > c_MAX_BCD);

  // Next count: preset over add over decrement; zero holds at zero
  always_comb begin
    w_count_nxt = r_count;
    if (preset_req[0]) begin
      w_count_nxt = c_PRESET0_V;
    end else if (preset_req[1]) begin
      w_count_nxt = c_PRESET1_V;
    end else if (w_is_add) begin
      w_count_nxt = w_sat ? c_MAX_BCD : w_alu_res;
    end else if (w_boundary && (r_count != 16'h0000)) begin
      w_count_nxt = w_alu_res;
    end
  end

  // Display enable follows the value about to be shown
  always_comb begin
    w_en_nxt = r_en;
    if (w_count_nxt >= c_LOW_BCD) begin
      w_en_nxt = 1'b1;
    end else if (w_count_nxt != 16'h0000) begin
      w_en_nxt = ~w_count_nxt[0];
    end else if (tick_2hz) begin
      w_en_nxt = ~r_en;
    end
  end

  // State registers; reset overrides every other input in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 16'h0000;
      r_phase <= 1'b0;
      r_en    <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_en    <= w_en_nxt;
      if (tick_2hz) r_phase <= ~r_phase;
    end
  end

  assign BCD_16bit = r_count;
  assign En_7seg   = r_en;

endmodule
`default_nettype wire

// File: tb/tb_parking_meter_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_meter_counter
// Description : Directed self-checking bench for parking_meter_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_meter_counter;

  logic        clk;
  logic        rst;
  logic        tick_2hz;
  logic [3:0]  add_req;
  logic [1:0]  preset_req;
  logic [15:0] BCD_16bit;
  logic        En_7seg;

  int checks   = 0;
  int failures = 0;

  parking_meter_counter dut (
    .clk        (clk),
    .rst        (rst),
    .tick_2hz   (tick_2hz),
    .add_req    (add_req),
    .preset_req (preset_req),
    .BCD_16bit  (BCD_16bit),
    .En_7seg    (En_7seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus, sampled 1 time unit after the edge
  task automatic cyc(input logic r, input logic t, input logic [3:0] a, input logic [1:0] p);
    @(negedge clk);
    rst        = r;
    tick_2hz   = t;
    add_req    = a;
    preset_req = p;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    tick_2hz   = 1'b0;
    add_req    = 4'd0;
    preset_req = 2'd0;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp_bcd, input logic exp_en);
    checks++;
    assert (BCD_16bit === exp_bcd) else begin
      failures++;
      $error("FAIL %s BCD_16bit got=%h exp=%h", tag, BCD_16bit, exp_bcd);
    end
    checks++;
    assert (En_7seg === exp_en) else begin
      failures++;
      $error("FAIL %s En_7seg got=%b exp=%b", tag, En_7seg, exp_en);
    end
  endtask

  initial begin
    rst = 1'b0; tick_2hz = 1'b0; add_req = 4'd0; preset_req = 2'd0;

    // Reset state
    cyc(1, 0, 4'd0, 2'd0);
    chk("reset", 16'h0000, 1'b1);

    // add_req[1] then four ticks: 0180 lit, 0179 dark, 0178 lit
    cyc(0, 0, 4'b0010, 2'd0);  chk("add180", 16'h0180, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("t1", 16'h0180, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("t2", 16'h0179, 1'b0);
    cyc(0, 1, 4'd0, 2'd0);     chk("t3", 16'h0179, 1'b0);
    cyc(0, 1, 4'd0, 2'd0);     chk("t4", 16'h0178, 1'b1);

    // Both presets: PRESET0 wins, then count to zero and flash
    cyc(1, 0, 4'd0, 2'd0);
    cyc(0, 0, 4'd0, 2'b11);    chk("preset11", 16'h0015, 1'b0);
    for (int i = 0; i < 30; i++) cyc(0, 1, 4'd0, 2'd0);
    chk("to_zero", 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 4'd0, 2'd0);
      chk("zero_flash", 16'h0000, (i % 2) == 1);
    end

    // Preset beats add; lowest add bit wins
    cyc(0, 0, 4'b0001, 2'b10); chk("preset_over_add", 16'h0150, 1'b1);
    cyc(0, 0, 4'b0110, 2'd0);  chk("add_lowbit", 16'h0330, 1'b1);

    // Saturation
    cyc(1, 0, 4'd0, 2'd0);
    for (int i = 0; i < 18; i++) cyc(0, 0, 4'b1000, 2'd0);
    for (int i = 0; i < 9; i++)  cyc(0, 0, 4'b0001, 2'd0);
    chk("to9990", 16'h9990, 1'b1);
    cyc(0, 0, 4'b1000, 2'd0);  chk("sat550", 16'h9999, 1'b1);
    cyc(0, 0, 4'b0001, 2'd0);  chk("sat10", 16'h9999, 1'b1);
    cyc(0, 0, 4'b1000, 2'd0);  chk("sat_carry", 16'h9999, 1'b1);

    // Add coincident with a second boundary drops that decrement
    cyc(1, 0, 4'd0, 2'd0);
    cyc(0, 0, 4'b0100, 2'd0);  chk("add200", 16'h0200, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("half", 16'h0200, 1'b1);
    cyc(0, 1, 4'b0001, 2'd0);  chk("add_on_boundary", 16'h0210, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("after_half", 16'h0210, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("after_dec", 16'h0209, 1'b1);

    // Borrow 1000 -> 0999
    cyc(1, 0, 4'd0, 2'd0);
    cyc(0, 0, 4'b1000, 2'd0);
    cyc(0, 0, 4'b0010, 2'd0);
    cyc(0, 0, 4'b0010, 2'd0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 4'b0001, 2'd0);
    chk("to1000", 16'h1000, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);
    cyc(0, 1, 4'd0, 2'd0);     chk("borrow1000", 16'h0999, 1'b1);

    // Borrow 0100 -> 0099
    cyc(1, 0, 4'd0, 2'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 4'b0001, 2'd0);
    chk("to0100", 16'h0100, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);
    cyc(0, 1, 4'd0, 2'd0);     chk("borrow0100", 16'h0099, 1'b0);

    // Reset overrides a coincident add and tick, and clears phase
    cyc(1, 0, 4'd0, 2'd0);
    cyc(0, 0, 4'b1000, 2'd0);  chk("to0550", 16'h0550, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("phase1", 16'h0550, 1'b1);
    cyc(1, 1, 4'b0100, 2'd0);  chk("rst_override", 16'h0000, 1'b1);
    cyc(0, 0, 4'b0001, 2'd0);  chk("post_rst_add", 16'h0010, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("phase_cleared", 16'h0010, 1'b1);
    cyc(0, 1, 4'd0, 2'd0);     chk("post_rst_dec", 16'h0009, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_meter_counter.md
# parking_meter_counter

Four-digit BCD countdown counter with button-driven time credit and display-flash control. It converts one-cycle button/preset strobes and a 2 Hz tick strobe into the 16-bit packed-BCD value and the display-enable flag consumed directly by the four-digit seven-segment display driver. All arithmetic is BCD-native, so the display stage needs no conversion.

## Interface
Parameters:
- MAX_COUNT, 9999: saturation ceiling, decimal.
- LOW_THRESH, 200: below this (and above 0), the display blinks on even seconds.
- ADD0 / ADD1 / ADD2 / ADD3, 10 / 180 / 200 / 550: seconds credited by add_req[0..3].
- PRESET0 / PRESET1, 15 / 150: values loaded by preset_req[0..1].

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- tick_2hz  in  1  one-clk strobe, twice per second.
- add_req  in  4  one-clk strobes, one per add button; already debounced and edge-detected.
- preset_req  in  2  one-clk strobes, load a preset.
- BCD_16bit  out  16  packed BCD count: [15:12] thousands down to [3:0] units.
- En_7seg  out  1  display enable; 1 = digits lit.

## Operation
- State:
  - count: 4 BCD digits.
  - phase: 1 bit, half-second phase.
  - en: 1 bit, drives En_7seg.
- Per-cycle priority, highest first:
  1. rst
  2. preset_req
  3. add_req
  4. decrement
- Exactly one action per cycle.
- Preset: lowest set bit of preset_req wins; count <= PRESETn.
- Add: lowest set bit of add_req wins; count <= min(count + ADDn, MAX_COUNT). Detect overflow from the digit-3 carry-out or from a result above MAX_COUNT.
- phase toggles on every tick_2hz, regardless of other actions.
- A second boundary is a tick_2hz with phase==1.
- Decrement: at a second boundary with no preset or add that cycle, count <= count − 1, with BCD borrow across digits. count==0 holds at 0.
- A preset or add coinciding with a second boundary drops that second's decrement.
- En_7seg rules, evaluated on the next count value:
  - count ≥ LOW_THRESH: en <= 1.
  - 0 < count < LOW_THRESH: en <= ~count[0]. Units digit even = lit; gives a 1 Hz blink since count changes once per second.
  - count == 0: en toggles on each tick_2hz; otherwise holds.
- Count is always legal BCD: each digit 0–9, with no intermediate non-BCD value on the output.

## Timing
- Reset values: count=0000, BCD_16bit=16'h0000, phase=0, en=1, En_7seg=1.
- All outputs are registered. Latency is 1 clk from the strobe to an updated BCD_16bit / En_7seg.
- Strobes are assumed one clk wide. A strobe held high N cycles acts N times.
- Reset mid-operation: any cycle with rst=1 forces the reset values and ignores all other inputs that cycle.
- Borrow chain examples:
  - 1000 → 0999
  - 0100 → 0099
  - 0001 → 0000
- After 0001 → 0000, en begins toggling on the next tick_2hz.
- Saturation: 9990 + 550 → 9999. Subsequent adds hold 9999.

## Structure
- Shared package, constants only:
  - BCD digit width (4).
  - Digit count (4).
  - Default ADD and PRESET values as packed BCD.
- Sub-module bcd4_add_sub:
  - Combinational 4-digit BCD adder/subtractor.
  - Inputs: a[15:0], b[15:0], sub.
  - Outputs: result[15:0], carry/borrow out.
  - Uses per-digit +6 / −6 correction.
  - The top level instantiates it once; b is muxed between ADDn and 16'h0001.
- Top level: priority mux, phase/en registers, saturation compare.

## Test plan
- Reset, then pulse add_req[1]: BCD_16bit=16'h0180 one clk later and En_7seg=1. Then 4 tick_2hz: BCD_16bit=16'h0178; En_7seg toggles 1→0→1 as units go 9→8 (lit on 0180, dark on 0179, lit on 0178).
- preset_req=2'b11 from 0000: BCD_16bit=16'h0015 (PRESET0 wins). Then 30 tick_2hz: reaches 0000. Next 4 ticks: En_7seg=0,1,0,1 and count stays 0000.
- Add chain to 9990, then add_req[3]: BCD_16bit=16'h9999. Repeat add_req[0]: holds 9999.
- add_req[0] on the same cycle as a second-boundary tick at count=0200: result 0210, no decrement. Next boundary gives 0209; phase continues unbroken.
- Borrow chain: preset to 1000 via adds, one second boundary: 0999 with En_7seg=1 (≥200). Separately, 0100 → 0099, En_7seg=0.
- Assert rst during count=0550 coincident with add_req[2] and tick_2hz: next cycle 0000, En_7seg=1, phase=0.
